rr_arbiter: RTL and testbench

//  Packet-locking round-robin arbiter for one switch output port; directly upstream of mux.

---
 rtl/noc_pkg.sv | 12 +
 rtl/rr_pick.sv | 29 ++
 rtl/rr_arbiter.sv | 80 ++++++++
 tb/tb_rr_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and helpers for the switch output-port control path.
package noc_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    // Round-robin pointer advance; wraps explicitly at n so non-power-of-two N never
    // produces an index past N-1.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap.
module rr_pick
    import noc_pkg::*;
#(
    parameter int N = 4,
    localparam int L = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [L-1:0] ptr,
    output logic         any,
    output logic [L-1:0] idx
);

    int j;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = int'(ptr);
        for (int i = 0; i < N; i++) begin
            if (!any && req[L'(j)]) begin
                any = 1'b1;
                idx = L'(j);
            end
            j = rr_next(j, N);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Packet-locking round-robin arbiter for one switch output port; drives the mux select.
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int N = 4,
    localparam int L = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    input  logic         o_ready,
    output logic [L-1:0] s,
    output logic         o_v,
    output logic [N-1:0] gnt
);

    arb_state_e   state;
    logic [L-1:0] ptr;
    logic         locked;
    logic         xfer;
    logic         rel;
    logic [L-1:0] nxt_ptr;
    logic [L-1:0] pick_ptr;
    logic [L-1:0] pick_idx;
    logic         pick_any;

    assign locked = (state == ARB_LOCKED);
    // Gated by rst so a lock left over from before reset never shows during reset.
    assign o_v    = !rst && locked && req[s];
    assign xfer   = o_v && o_ready;
    assign rel    = xfer && last[s];

    // On release the just-finished input drops to lowest priority for the same-cycle re-pick.
    assign nxt_ptr  = L'(rr_next(int'(s), N));
    assign pick_ptr = rel ? nxt_ptr : ptr;

    always_comb begin
        gnt = '0;
        if (!rst && locked && o_ready) begin
            gnt[s] = 1'b1;
        end
    end

    rr_pick #(.N(N)) u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            s     <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        s     <= pick_idx;
                        state <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (rel) begin
                        ptr <= nxt_ptr;
                        if (pick_any) begin
                            s <= pick_idx;
                        end else begin
                            state <= ARB_IDLE;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter at N=4 (with a 32-bit data mux on the select) and N=3.
module tb_rr_arbiter;

    logic clk;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int NN = (g == 0) ? 4 : 3;
        localparam int LL = $clog2(NN);

        typedef struct {
            logic          v;
            logic [LL-1:0] s;
            logic [NN-1:0] gnt;
            logic          chk_s;
            string         tag;
        } exp_t;

        logic          rst;
        logic          o_ready;
        logic [NN-1:0] req;
        logic [NN-1:0] last;
        logic [LL-1:0] s;
        logic          o_v;
        logic [NN-1:0] gnt;
        logic [31:0]   din [NN];
        logic [31:0]   mux_o;
        logic          done = 1'b0;

        exp_t q[$];
        exp_t e;

        // Reference model: who owns the port and where the rotation starts.
        int owner = -1;
        int rr    = 0;
        int ms    = 0;

        rr_arbiter #(.N(NN)) dut (
            .clk     (clk),
            .rst     (rst),
            .req     (req),
            .last    (last),
            .o_ready (o_ready),
            .s       (s),
            .o_v     (o_v),
            .gnt     (gnt)
        );

        assign mux_o = din[s];

        function automatic int first_from(input logic [NN-1:0] r, input int p);
            for (int i = 0; i < NN; i++) begin
                if (r[(p + i) % NN]) return (p + i) % NN;
            end
            return -1;
        endfunction

        task automatic step(input logic r, input logic [NN-1:0] rq, input logic [NN-1:0] ls,
                            input logic rdy, input string tag);
            exp_t x;
            int   w;
            @(posedge clk);
            #1;
            rst = r; req = rq; last = ls; o_ready = rdy;
            #1;
            x.v     = !r && owner >= 0 && rq[owner];
            x.gnt   = (!r && owner >= 0 && rdy) ? (NN'(1) << owner) : '0;
            x.s     = LL'(ms);
            x.chk_s = !r;
            x.tag   = tag;
            q.push_back(x);
            if (r) begin
                owner = -1; rr = 0; ms = 0;
            end else if (owner < 0) begin
                w = first_from(rq, rr);
                if (w >= 0) begin owner = w; ms = w; end
            end else if (rq[owner] && rdy && ls[owner]) begin
                rr = (owner + 1) % NN;
                w  = first_from(rq, rr);
                owner = w;
                if (w >= 0) ms = w;
            end
        endtask

        always @(negedge clk) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("N%0d %s o_v", NN, e.tag), 32'(o_v), 32'(e.v));
                check($sformatf("N%0d %s gnt", NN, e.tag), 32'(gnt), 32'(e.gnt));
                if (e.chk_s) begin
                    check($sformatf("N%0d %s s", NN, e.tag), 32'(s), 32'(e.s));
                    check($sformatf("N%0d %s s_range", NN, e.tag), 32'(int'(s) < NN), 32'd1);
                end
                if (e.v) check($sformatf("N%0d %s mux_o", NN, e.tag), mux_o, din[e.s]);
            end
        end

        initial begin
            din[0] = 32'hCAFE0000;
            din[1] = 32'h12341234;
            if (NN > 2) din[2] = 32'h56785678;
            if (NN > 3) din[3] = 32'h9ABC9ABC;
            rst = 1'b1; req = '0; last = '0; o_ready = 1'b0;
            if (NN == 4) begin
                // reset with all requesting, then rotation 0,1,2,3,0
                step(1, '1, '0, 1, "reset");
                step(1, '1, '0, 1, "reset");
                for (int i = 0; i < 7; i++) step(0, '1, '1, 1, "rotate");
                // packet lock on input 1 with input 2 waiting
                step(1, '0, '0, 1, "rst");
                step(0, 4'b0110, 4'b0000, 1, "lock");
                step(0, 4'b0110, 4'b0000, 1, "lock");
                step(0, 4'b0110, 4'b0000, 1, "lock");
                step(0, 4'b0110, 4'b0110, 1, "lock");
                step(0, 4'b0100, 4'b0000, 1, "lock");
                // gap: granted input drops req mid-packet
                step(0, 4'b0000, 4'b0000, 1, "gap");
                step(0, 4'b0101, 4'b0100, 1, "gap");
                step(0, 4'b0001, 4'b0001, 1, "gap");
                // stall on input 3, then release wraps ptr to 0
                step(1, '0, '0, 0, "rst");
                step(0, 4'b1000, 4'b1000, 0, "stall");
                for (int i = 0; i < 5; i++) step(0, 4'b1000, 4'b1000, 0, "stall");
                step(0, 4'b1111, 4'b1000, 1, "stall");
                step(0, 4'b1111, 4'b0000, 1, "stall");
                // reset mid-packet on input 2
                step(1, '0, '0, 1, "rst");
                step(0, 4'b0100, 4'b0000, 1, "midrst");
                step(0, 4'b0100, 4'b0000, 1, "midrst");
                step(1, 4'b0100, 4'b0000, 1, "midrst");
                step(0, 4'b0110, 4'b0000, 1, "midrst");
                step(0, 4'b0110, 4'b0000, 1, "midrst");
            end else begin
                step(1, '1, '0, 1, "reset");
                step(1, '1, '0, 1, "reset");
                for (int i = 0; i < 6; i++) step(0, 3'b101, '1, 1, "wrap3");
                step(0, 3'b111, 3'b100, 1, "wrap3");
                step(0, 3'b111, 3'b111, 1, "wrap3");
                step(0, 3'b111, 3'b111, 1, "wrap3");
            end
            for (int i = 0; i < 400; i++) begin
                step(($urandom_range(0, 49) == 0), NN'($urandom), NN'($urandom),
                     ($urandom_range(0, 3) != 0), "random");
            end
            done = 1'b1;
        end
    end

    initial begin
        int cyc = 0;
        while (!(h[0].done && h[1].done) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 20000) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d cycles expected < 20000", cyc);
        end
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
